// File: rtl/threshold_filter.sv
// threshold_filter
//   Binarizing stage placed ahead of the BMP writer. Each accepted even/odd
//   RGB pair is reduced to an integer luma per pixel, gray = (R + 2G + B) >> 2,
//   and each pixel is replaced by pure white (gray >= threshold) or pure
//   black. One frame is exactly IMAGE_WIDTH*IMAGE_HEIGHT pixels, and a
//   one-cycle strobe marks its end.
//
// Ports
//   clk, reset           : rising-edge clock, asynchronous active-high reset
//   start                : frame start request (honoured only in IDLE)
//   threshold_Value      : threshold, latched when start is accepted
//   in_Valid, in_*_Even, in_*_Odd      : input pixel pair (accepted only in RUN)
//   horizontal_Pulse, data_*_Even/Odd  : binarized pair and its valid flag
//   sig_Process_Done     : one-cycle end-of-frame strobe
//   busy                 : high while in RUN or DRAIN
//   dbg_state_o          : current FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3)
//
// Handshake: a pair transfers on every rising edge where in_Valid=1 and the
// block is in RUN. There is no ready signal: the block never stalls, and the
// downstream writer takes every cycle where horizontal_Pulse=1. A pair
// accepted at edge N is presented after edge N+2.
module threshold_filter #(
  parameter int IMAGE_WIDTH  = 768,
  parameter int IMAGE_HEIGHT = 512
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] threshold_Value,
  input  logic       in_Valid,
  input  logic [7:0] in_Red_Even,
  input  logic [7:0] in_Green_Even,
  input  logic [7:0] in_Blue_Even,
  input  logic [7:0] in_Red_Odd,
  input  logic [7:0] in_Green_Odd,
  input  logic [7:0] in_Blue_Odd,
  output logic       horizontal_Pulse,
  output logic [7:0] data_Red_Even,
  output logic [7:0] data_Green_Even,
  output logic [7:0] data_Blue_Even,
  output logic [7:0] data_Red_Odd,
  output logic [7:0] data_Green_Odd,
  output logic [7:0] data_Blue_Odd,
  output logic       sig_Process_Done,
  output logic       busy,
  output logic [1:0] dbg_state_o
);

  localparam int COLS = IMAGE_WIDTH / 2;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW   = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMAGE_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q;
  logic [CW-1:0] col_cnt_q;
  logic [RW-1:0] row_cnt_q;
  logic [7:0]    thr_q;
  logic          drain_cnt_q;

  logic accept;
  logic last_pair;

  assign accept      = (state_q == RUN) && in_Valid;
  assign last_pair   = (col_cnt_q == LAST_COL) && (row_cnt_q == LAST_ROW);
  assign dbg_state_o = state_q;

  // Control FSM. busy and sig_Process_Done are registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      col_cnt_q        <= '0;
      row_cnt_q        <= '0;
      thr_q            <= '0;
      drain_cnt_q      <= 1'b0;
      busy             <= 1'b0;
      sig_Process_Done <= 1'b0;
    end else begin
      sig_Process_Done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= RUN;
            thr_q     <= threshold_Value;
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          if (in_Valid) begin
            if (last_pair) begin
              state_q     <= DRAIN;
              drain_cnt_q <= 1'b0;
            end else if (col_cnt_q == LAST_COL) begin
              col_cnt_q <= '0;
              row_cnt_q <= row_cnt_q + RW'(1);
            end else begin
              col_cnt_q <= col_cnt_q + CW'(1);
            end
          end
        end
        DRAIN: begin
          // Two cycles: enough for the final pair to leave the pipeline.
          if (drain_cnt_q) begin
            state_q <= DONE;
            busy    <= 1'b0;
          end else begin
            drain_cnt_q <= 1'b1;
          end
        end
        DONE: begin
          state_q          <= IDLE;
          sig_Process_Done <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Capture register: holds the pair accepted on this edge so the two
  // arithmetic stages that follow see stable operands.
  logic       v0_q;
  logic [7:0] r_e_q, g_e_q, b_e_q, r_o_q, g_o_q, b_o_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v0_q  <= 1'b0;
      r_e_q <= '0;
      g_e_q <= '0;
      b_e_q <= '0;
      r_o_q <= '0;
      g_o_q <= '0;
      b_o_q <= '0;
    end else begin
      v0_q <= accept;
      if (accept) begin
        r_e_q <= in_Red_Even;
        g_e_q <= in_Green_Even;
        b_e_q <= in_Blue_Even;
        r_o_q <= in_Red_Odd;
        g_o_q <= in_Green_Odd;
        b_o_q <= in_Blue_Odd;
      end
    end
  end

  // Stage 1: luma sums, R + 2G + B, at most 1020 so 10 bits suffice.
  logic [9:0] sum_even_d, sum_odd_d;
  logic [9:0] sum_even_q, sum_odd_q;
  logic       v1_q;

  assign sum_even_d = {2'b00, r_e_q} + {1'b0, g_e_q, 1'b0} + {2'b00, b_e_q};
  assign sum_odd_d  = {2'b00, r_o_q} + {1'b0, g_o_q, 1'b0} + {2'b00, b_o_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q       <= 1'b0;
      sum_even_q <= '0;
      sum_odd_q  <= '0;
    end else begin
      v1_q <= v0_q;
      if (v0_q) begin
        sum_even_q <= sum_even_d;
        sum_odd_q  <= sum_odd_d;
      end
    end
  end

  // Stage 2: (sum >> 2) >= thr is the same test as sum >= 4*thr for
  // integers, so the truncated gray value never needs to be formed.
  logic white_even, white_odd;

  assign white_even = sum_even_q >= {thr_q, 2'b00};
  assign white_odd  = sum_odd_q  >= {thr_q, 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      horizontal_Pulse <= 1'b0;
      data_Red_Even    <= '0;
      data_Green_Even  <= '0;
      data_Blue_Even   <= '0;
      data_Red_Odd     <= '0;
      data_Green_Odd   <= '0;
      data_Blue_Odd    <= '0;
    end else begin
      horizontal_Pulse <= v1_q;
      // Data holds its previous value between pulses.
      if (v1_q) begin
        data_Red_Even   <= {8{white_even}};
        data_Green_Even <= {8{white_even}};
        data_Blue_Even  <= {8{white_even}};
        data_Red_Odd    <= {8{white_odd}};
        data_Green_Odd  <= {8{white_odd}};
        data_Blue_Odd   <= {8{white_odd}};
      end
    end
  end

endmodule

// File: tb/tb_threshold_filter.sv
// Testbench for threshold_filter on a 32x8 frame (128 pairs per frame).
// Inputs are driven on the falling edge; a reference model updates on the
// rising edge and pushes expected pairs to exp_q; a monitor on the falling
// edge pops and compares, and checks pulse timing, busy and the done strobe.
module tb_threshold_filter;

  localparam int W  = 32;
  localparam int H  = 8;
  localparam int NP = W * H / 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] threshold_Value;
  logic       in_Valid;
  logic [7:0] re, ge, be, ro, go, bo;
  logic       horizontal_Pulse;
  logic [7:0] dre, dge, dbe, dro, dgo, dbo;
  logic       sig_Process_Done;
  logic       busy;
  logic [1:0] dbg_state;

  threshold_filter #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .threshold_Value  (threshold_Value),
    .in_Valid         (in_Valid),
    .in_Red_Even      (re),
    .in_Green_Even    (ge),
    .in_Blue_Even     (be),
    .in_Red_Odd       (ro),
    .in_Green_Odd     (go),
    .in_Blue_Odd      (bo),
    .horizontal_Pulse (horizontal_Pulse),
    .data_Red_Even    (dre),
    .data_Green_Even  (dge),
    .data_Blue_Even   (dbe),
    .data_Red_Odd     (dro),
    .data_Green_Odd   (dgo),
    .data_Blue_Odd    (dbo),
    .sig_Process_Done (sig_Process_Done),
    .busy             (busy),
    .dbg_state_o      (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          pulse_cnt = 0;
  int          done_cnt  = 0;
  logic [47:0] exp_q[$];
  logic [47:0] last_data = '0;

  logic [47:0] dout;
  assign dout = {dre, dge, dbe, dro, dgo, dbo};

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] bin_px(input logic [7:0] r, input logic [7:0] g,
                                         input logic [7:0] b, input logic [7:0] thr);
    int s;
    s = int'(r) + 2 * int'(g) + int'(b);
    return ((s / 4) >= int'(thr)) ? 24'hFF_FFFF : 24'h00_0000;
  endfunction

  // ---------------- reference model ----------------
  logic       run_m;
  int         cnt_m;
  logic [7:0] thr_m;
  logic [2:0] acch;   // acceptance history, bit k = accepted k edges ago
  logic [3:0] lasth;  // last-pair acceptance history
  logic       acc_m, lst_m;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      run_m <= 1'b0;
      cnt_m <= 0;
      thr_m <= '0;
      acch  <= '0;
      lasth <= '0;
      exp_q.delete();
    end else begin
      acc_m = run_m && in_Valid;
      lst_m = acc_m && (cnt_m == NP - 1);
      if (acc_m) begin
        exp_q.push_back({bin_px(re, ge, be, thr_m), bin_px(ro, go, bo, thr_m)});
        cnt_m <= cnt_m + 1;
      end
      if (lst_m) run_m <= 1'b0;
      if (!run_m && (lasth[2:0] == 3'b000) && start) begin
        run_m <= 1'b1;
        cnt_m <= 0;
        thr_m <= threshold_Value;
      end
      acch  <= {acch[1:0], acc_m};
      lasth <= {lasth[2:0], lst_m};
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset) last_data = '0;
    chk("pulse_timing", {47'd0, horizontal_Pulse}, {47'd0, acch[2]});
    chk("done_timing",  {47'd0, sig_Process_Done}, {47'd0, lasth[3]});
    chk("busy",         {47'd0, busy}, {47'd0, run_m | lasth[0] | lasth[1]});
    if (horizontal_Pulse) begin
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        chk("pulse_without_pair", {47'd0, horizontal_Pulse}, 48'd0);
      end else begin
        logic [47:0] e;
        e = exp_q.pop_front();
        chk("pair_data", dout, e);
        last_data = e;
      end
    end else begin
      chk("data_hold", dout, last_data);
    end
    if (sig_Process_Done) done_cnt++;
  end

  // ---------------- driver ----------------
  // mode: 0 = even 128s / odd (127,128,128), 1 = zeros,
  //       2 = even 255s / odd (255,254,255), 3 = random
  // gap: in_Valid follows 1,0,0,... ; stop_after >= 0 aborts after that many pairs
  // disturb: change threshold_Value and pulse start mid-frame
  task automatic run_frame(input logic [7:0] thr, input int mode, input bit gap,
                           input int stop_after, input bit disturb);
    int sent, slot;
    logic v;
    pulse_cnt = 0;
    done_cnt  = 0;
    @(negedge clk);
    start = 1'b1;
    threshold_Value = thr;
    in_Valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    sent = 0;
    slot = 0;
    while (sent < NP && !(stop_after >= 0 && sent == stop_after)) begin
      v = gap ? (slot % 3 == 0) : 1'b1;
      in_Valid = v;
      case (mode)
        0: begin re = 8'd128; ge = 8'd128; be = 8'd128; ro = 8'd127; go = 8'd128; bo = 8'd128; end
        1: begin re = 8'd0;   ge = 8'd0;   be = 8'd0;   ro = 8'd0;   go = 8'd0;   bo = 8'd0;   end
        2: begin re = 8'd255; ge = 8'd255; be = 8'd255; ro = 8'd255; go = 8'd254; bo = 8'd255; end
        default: begin
          re = 8'($urandom_range(0, 255)); ge = 8'($urandom_range(0, 255));
          be = 8'($urandom_range(0, 255)); ro = 8'($urandom_range(0, 255));
          go = 8'($urandom_range(0, 255)); bo = 8'($urandom_range(0, 255));
        end
      endcase
      start = (disturb && slot == 20);
      if (disturb && slot == 10) threshold_Value = ~thr;
      if (v) sent++;
      slot++;
      @(negedge clk);
    end
    in_Valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic finish_frame(input string tag);
    repeat (8) @(negedge clk);
    chk({tag, "_pulse_count"}, 48'(pulse_cnt), 48'(NP));
    chk({tag, "_done_count"}, 48'(done_cnt), 48'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    start = 1'b0;
    in_Valid = 1'b0;
    threshold_Value = 8'd0;
    re = '0; ge = '0; be = '0; ro = '0; go = '0; bo = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", 48'(dbg_state), 48'd0);
    chk("reset_data", dout, 48'd0);
    chk("reset_done", {47'd0, sig_Process_Done}, 48'd0);
    reset = 1'b0;

    // in_Valid outside RUN must not produce pulses
    in_Valid = 1'b1;
    re = 8'd200; ge = 8'd200; be = 8'd200; ro = 8'd10; go = 8'd10; bo = 8'd10;
    repeat (5) @(negedge clk);
    chk("idle_no_pulse", 48'(pulse_cnt), 48'd0);
    in_Valid = 1'b0;

    // Threshold boundary patterns
    run_frame(8'd128, 0, 1'b0, -1, 1'b0);
    finish_frame("thr128");
    run_frame(8'd0, 1, 1'b0, -1, 1'b0);
    finish_frame("thr0_zeros");
    run_frame(8'd255, 2, 1'b0, -1, 1'b0);
    finish_frame("thr255");

    // Gapped input, mid-frame start and threshold change
    run_frame(8'($urandom_range(40, 200)), 3, 1'b1, -1, 1'b1);
    finish_frame("gapped");

    // Reset after 100 pairs
    run_frame(8'd100, 3, 1'b0, 100, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_pulse", {47'd0, horizontal_Pulse}, 48'd0);
    chk("async_reset_busy", {47'd0, busy}, 48'd0);
    chk("async_reset_data", dout, 48'd0);
    chk("async_reset_state", 48'(dbg_state), 48'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    repeat (10) @(negedge clk);
    chk("no_done_after_reset", 48'(done_cnt), 48'd0);

    // Full frame after the aborted one
    run_frame(8'($urandom_range(0, 255)), 3, 1'b0, -1, 1'b0);
    finish_frame("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/threshold_filter.md
# threshold_filter

Binarizing stage that sits directly upstream of the BMP writer. It takes even/odd RGB pixel pairs from the image reader and computes an integer luma per pixel. Each pixel is replaced by pure white (255,255,255) or pure black (0,0,0) against a runtime threshold. It presents the result to the writer as pixel pairs qualified by `horizontal_Pulse`, and flags the end of a frame after exactly IMAGE_WIDTH×IMAGE_HEIGHT pixels.

## Interface
- `IMAGE_WIDTH`, 768: pixels per row; must be even.
- `IMAGE_HEIGHT`, 512: rows per frame.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `start` input 1: one-cycle frame start request.
- `threshold_Value` input 8: threshold, latched on accepted `start`.
- `in_Valid` input 1: input pixel pair valid.
- `in_Red_Even`, `in_Green_Even`, `in_Blue_Even` input 8 each: even pixel components.
- `in_Red_Odd`, `in_Green_Odd`, `in_Blue_Odd` input 8 each: odd pixel components.
- `horizontal_Pulse` output 1: output pair valid; goes to the writer.
- `data_Red_Even`, `data_Green_Even`, `data_Blue_Even` output 8 each: binarized even pixel.
- `data_Red_Odd`, `data_Green_Odd`, `data_Blue_Odd` output 8 each: binarized odd pixel.
- `sig_Process_Done` output 1: one-cycle end-of-frame strobe.
- `busy` output 1: high in RUN and DRAIN.

## Operation
- States:
  - IDLE: default.
  - RUN: accepting pairs.
  - DRAIN: waits for the pipeline to empty.
  - DONE: one cycle.
- IDLE → RUN on `start`; `threshold_Value` is latched into `thr_q` on the same edge.
- RUN: each cycle with `in_Valid`=1 accepts one pair and advances the counters.
  - `col_cnt` runs 0..IMAGE_WIDTH/2−1 and wraps to 0.
  - On wrap, `row_cnt` increments (0..IMAGE_HEIGHT−1).
- RUN → DRAIN on the cycle the last pair is accepted (`col_cnt`=IMAGE_WIDTH/2−1, `row_cnt`=IMAGE_HEIGHT−1, `in_Valid`=1).
- DRAIN lasts 2 cycles, then DONE. DONE asserts `sig_Process_Done` and returns to IDLE on the next cycle.
- `in_Valid` is ignored outside RUN.
- `start` is ignored outside IDLE.
- Luma per pixel: `sum = R + 2·G + B`, 10-bit unsigned, max 1020. Then `gray = sum >> 2`, 8-bit, truncating.
- Decision is inclusive: `gray >= thr_q` gives 255 on all three channels; otherwise 0.
  - `thr_q`=0 makes every pixel white.
  - `thr_q`=255 whitens only gray=255.
- Even and odd pixels are decided independently.
- Pipeline stage 1 registers the two `sum` values and a valid bit. Stage 2 registers the compare results and drives the outputs.
- Exactly IMAGE_WIDTH·IMAGE_HEIGHT/2 `horizontal_Pulse` cycles per frame, in input order, with no reordering or drops.
- Counters reset to 0 when RUN is entered.

## Timing
- Latency: a pair accepted at edge N appears with `horizontal_Pulse`=1 after edge N+2.
- Throughput: one pair per cycle. Gaps in `in_Valid` propagate as gaps in `horizontal_Pulse`.
- There is no backpressure; the writer always accepts.
- Data outputs hold their last value when `horizontal_Pulse`=0. Reset value is 0.
- `sig_Process_Done` rises on the 3rd edge after the last-pair acceptance edge, i.e. one cycle after the final `horizontal_Pulse`. Its width is exactly 1 cycle.
- `busy` is 1 from the edge after `start` until the cycle before DONE.
- Reset (any time, including mid-frame) forces, asynchronously:
  - state IDLE;
  - counters and `thr_q` to 0;
  - pipeline valids to 0;
  - all outputs to 0.
- No partial-frame `sig_Process_Done` is generated after reset.
- `start` coincident with reset deassertion is ignored.
- `threshold_Value` changes during RUN have no effect until the next `start`.

## Test plan
- Reset mid-frame after 100 pairs → outputs, `busy`, `horizontal_Pulse` go 0 immediately. No `sig_Process_Done` follows. A new `start` gives a full frame.
- 8×2 image, thr=128, all pairs even=(128,128,128), odd=(127,128,128) → 8 pulses, each even=255s, odd=0s. `sig_Process_Done` comes 1 cycle after the 8th pulse.
- thr=0 with all-zero pixels → every output 255. thr=255 with pixel (255,255,255) → 255. thr=255 with pixel (255,254,255) → 0, since gray=254.
- `in_Valid` toggled 1,0,0,1,... → pulses reproduce the same gaps delayed by 2 cycles, and the pulse count is exact.
- `start` pulsed during RUN and `threshold_Value` changed mid-frame → no restart, and the decision keeps using the latched threshold.
- Default 768×512 frame streamed back-to-back → exactly 196608 pulses and one `sig_Process_Done`. `busy` stays high continuously.
